ibus_arbiter: RTL and testbench

IBUS_ARBITER -- requirements
Module: ibus_arbiter

---
 rtl/tinyriscv_pkg.sv | 21 ++
 rtl/ibus_arbiter.sv | 131 +++++++++++++
 tb/tb_ibus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared types for the instruction-bus arbiter: bus widths and arbiter state/owner encodings.
package tinyriscv_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_M0,
        BUSY_M0_DROP,
        BUSY_M1
    } ibus_state_e;

    typedef enum logic {
        OWN_M0,
        OWN_M1
    } ibus_owner_e;

    localparam int unsigned FAIR_CNT_W = 4;

endpackage

// File: rtl/ibus_arbiter.sv
// Two-master instruction-bus arbiter (m0 = core fetch, m1 = debug/loader); optional IBUS_ARB_FAIRNESS_EN.
// Latency: request/grant and response routing are combinational (0 cycles); one transaction outstanding.
// Backpressure: an unaccepted request is locked to its owner until s_gnt_i; no new request while busy.
import tinyriscv_pkg::*;

module ibus_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       m0_req_i,
    input  InstAddrBus m0_addr_i,
    output logic       m0_gnt_o,
    output logic       m0_rvalid_o,
    output InstBus     m0_rdata_o,
    input  logic       m0_flush_i,
    input  logic       m1_req_i,
    input  logic       m1_we_i,
    input  InstAddrBus m1_addr_i,
    input  InstBus     m1_wdata_i,
    output logic       m1_gnt_o,
    output logic       m1_rvalid_o,
    output InstBus     m1_rdata_o,
    output logic       s_req_o,
    output logic       s_we_o,
    output InstAddrBus s_addr_o,
    output InstBus     s_wdata_o,
    input  logic       s_gnt_i,
    input  logic       s_rvalid_i,
    input  InstBus     s_rdata_i,
    output logic       m0_hold_o
);

    ibus_state_e state;
    logic        locked;
    ibus_owner_e lock_owner;
    ibus_owner_e win_owner;
    logic        win_vld;
    logic        present;
    logic        fair_m0;

`ifdef IBUS_ARB_FAIRNESS_EN
    logic [FAIR_CNT_W-1:0] fair_cnt;

    assign fair_m0 = m0_req_i && (fair_cnt >= FAIR_CNT_W'(FAIR_LIMIT));

    // Streak of m1 grants that m0 has been made to wait through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fair_cnt <= '0;
        end else if (!m0_req_i || m0_gnt_o) begin
            fair_cnt <= '0;
        end else if (m1_gnt_o && fair_cnt != {FAIR_CNT_W{1'b1}}) begin
            fair_cnt <= fair_cnt + 1'b1;
        end
    end
`else
    assign fair_m0 = 1'b0;
`endif

    always_comb begin
        win_owner = OWN_M0;
        win_vld   = 1'b0;
        if (locked) begin
            win_owner = lock_owner;
            win_vld   = (lock_owner == OWN_M1) ? m1_req_i : m0_req_i;
        end else if (fair_m0) begin
            win_owner = OWN_M0;
            win_vld   = 1'b1;
        end else if (m1_req_i) begin
            win_owner = OWN_M1;
            win_vld   = 1'b1;
        end else if (m0_req_i) begin
            win_owner = OWN_M0;
            win_vld   = 1'b1;
        end
    end

    // rst_ni gating keeps input-derived outputs quiet while reset is held.
    assign present   = rst_ni && (state == IDLE) && win_vld;
    assign s_req_o   = present;
    assign s_we_o    = present && (win_owner == OWN_M1) && m1_we_i;
    assign s_addr_o  = !present ? '0 : (win_owner == OWN_M1) ? m1_addr_i : m0_addr_i;
    assign s_wdata_o = (present && win_owner == OWN_M1) ? m1_wdata_i : '0;
    assign m0_gnt_o  = present && (win_owner == OWN_M0) && s_gnt_i;
    assign m1_gnt_o  = present && (win_owner == OWN_M1) && s_gnt_i;

    assign m0_rvalid_o = rst_ni && (state == BUSY_M0) && s_rvalid_i && !m0_flush_i;
    assign m1_rvalid_o = rst_ni && (state == BUSY_M1) && s_rvalid_i;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

    assign m0_hold_o = rst_ni && (m1_req_i || state == BUSY_M1 || (locked && lock_owner == OWN_M1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            locked     <= 1'b0;
            lock_owner <= OWN_M0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (present && s_gnt_i) begin
                        state  <= (win_owner == OWN_M1) ? BUSY_M1 : BUSY_M0;
                        locked <= 1'b0;
                    end else if (present) begin
                        // A flushed core fetch gives up its claim on the port.
                        locked     <= !(win_owner == OWN_M0 && m0_flush_i);
                        lock_owner <= win_owner;
                    end else begin
                        locked <= 1'b0;
                    end
                end
                BUSY_M0: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                    end else if (m0_flush_i) begin
                        state <= BUSY_M0_DROP;
                    end
                end
                BUSY_M0_DROP, BUSY_M1: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed and randomized checks of ibus_arbiter against a cycle-level reference model.
module tb_ibus_arbiter;

    localparam int unsigned FAIR_LIMIT = 4;
`ifdef IBUS_ARB_FAIRNESS_EN
    localparam bit FAIR_ON = 1'b1;
`else
    localparam bit FAIR_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m0_flush_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i, m0_hold_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [6:0]  ctl;
    logic [127:0] dat;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    ibus_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_flush_i(m0_flush_i),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .m0_hold_o(m0_hold_o)
    );

    // ctl bits: s_req, s_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_hold
    assign ctl = {s_req_o, s_we_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_hold_o};
    assign dat = {s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o};

    task automatic idle_inputs();
        m0_req_i = 0; m0_flush_i = 0; m1_req_i = 0; m1_we_i = 0;
        m0_addr_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        m0_req_i = 1; m1_req_i = 1; m1_we_i = 1; m0_addr_i = 32'h44; m1_addr_i = 32'h88;
        m1_wdata_i = 32'hCAFE; s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hFFFF; m0_flush_i = 0;
        #2;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0); end
        n_checks++;
        if (dat !== 128'b0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", dat); end
        tick(); tick();
        idle_inputs();
        rst_ni = 1;
        tick();
    endtask

    task automatic test_m0_fetch();
        m0_req_i = 1; m0_addr_i = 32'h100; s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1010000) begin n_fail++; $display("FAIL m0_grant_ctl: got %b expected %b", ctl, 7'b1010000); end
        n_checks++;
        if (s_addr_o !== 32'h100) begin n_fail++; $display("FAIL m0_addr: got %h expected %h", s_addr_o, 32'h100); end
        tick();
        m0_addr_i = 32'h104; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h00000013;
        #2;
        n_checks++;
        if (ctl !== 7'b0000100) begin n_fail++; $display("FAIL m0_resp_ctl: got %b expected %b", ctl, 7'b0000100); end
        n_checks++;
        if (m0_rdata_o !== 32'h13) begin n_fail++; $display("FAIL m0_rdata: got %h expected %h", m0_rdata_o, 32'h13); end
        tick();
        m0_req_i = 0; s_rvalid_i = 0; s_rdata_i = 32'h55;
        #2;
        n_checks++;
        if (ctl !== 7'b0 || m0_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL m0_quiet: got %b/%h expected 0/0", ctl, m0_rdata_o);
        end
        tick();
    endtask

    task automatic test_m1_priority();
        m0_req_i = 1; m0_addr_i = 32'h300;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'hDEADBEEF; s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1101001) begin n_fail++; $display("FAIL m1_prio_ctl: got %b expected %b", ctl, 7'b1101001); end
        n_checks++;
        if (s_addr_o !== 32'h200 || s_wdata_o !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL m1_write_bus: got %h/%h expected 200/deadbeef", s_addr_o, s_wdata_o);
        end
        tick();
        idle_inputs(); s_rvalid_i = 1; s_rdata_i = 32'hA5A5;
        #2;
        n_checks++;
        if (ctl !== 7'b0000011) begin n_fail++; $display("FAIL m1_resp_ctl: got %b expected %b", ctl, 7'b0000011); end
        n_checks++;
        if (m1_rdata_o !== 32'hA5A5 || m0_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL m1_rdata: got %h/%h expected a5a5/0", m1_rdata_o, m0_rdata_o);
        end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_lock();
        m0_req_i = 1; m0_addr_i = 32'h400; s_gnt_i = 0;
        #2;
        n_checks++;
        if (ctl !== 7'b1000000) begin n_fail++; $display("FAIL lock_present: got %b expected %b", ctl, 7'b1000000); end
        tick();
        m1_req_i = 1; m1_addr_i = 32'h500;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_checks++;
            if (s_addr_o !== 32'h400 || ctl !== 7'b1000001) begin
                n_fail++; $display("FAIL lock_hold: got %h/%b expected 400/%b", s_addr_o, ctl, 7'b1000001);
            end
            tick();
        end
        s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1010001) begin n_fail++; $display("FAIL lock_m0_first: got %b expected %b", ctl, 7'b1010001); end
        tick();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h77;
        #2;
        n_checks++;
        if (ctl !== 7'b0000101) begin n_fail++; $display("FAIL lock_m0_resp: got %b expected %b", ctl, 7'b0000101); end
        tick();
        s_rvalid_i = 0; s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1001001 || s_addr_o !== 32'h500) begin
            n_fail++; $display("FAIL lock_m1_next: got %b/%h expected %b/500", ctl, s_addr_o, 7'b1001001);
        end
        tick();
        idle_inputs(); s_rvalid_i = 1;
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_flush();
        m0_req_i = 1; m0_addr_i = 32'h600; s_gnt_i = 1;
        tick();
        s_gnt_i = 0; m0_flush_i = 1; m0_addr_i = 32'h700;
        #2;
        n_checks++;
        if (ctl !== 7'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected %b", ctl, 7'b0); end
        tick();
        m0_flush_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h99;
        #2;
        n_checks++;
        if (ctl !== 7'b0 || m0_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL flush_drop: got %b/%h expected 0/0", ctl, m0_rdata_o);
        end
        tick();
        s_rvalid_i = 0; s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1010000) begin n_fail++; $display("FAIL flush_idle_again: got %b expected %b", ctl, 7'b1010000); end
        tick();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; m0_flush_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b0 || m0_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL flush_same_cycle: got %b/%h expected 0/0", ctl, m0_rdata_o);
        end
        tick();
        idle_inputs(); m0_req_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1000000) begin n_fail++; $display("FAIL flush_returns_idle: got %b expected %b", ctl, 7'b1000000); end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_flush_unlock();
        m0_req_i = 1; m0_addr_i = 32'h800;
        tick();
        m1_req_i = 1; m1_addr_i = 32'h900; m0_flush_i = 1;
        #2;
        n_checks++;
        if (s_addr_o !== 32'h800) begin n_fail++; $display("FAIL unlock_still_m0: got %h expected %h", s_addr_o, 32'h800); end
        tick();
        m0_flush_i = 0; s_gnt_i = 1;
        #2;
        n_checks++;
        if (ctl !== 7'b1001001 || s_addr_o !== 32'h900) begin
            n_fail++; $display("FAIL unlock_m1_wins: got %b/%h expected %b/900", ctl, s_addr_o, 7'b1001001);
        end
        tick();
        idle_inputs(); s_rvalid_i = 1;
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_stray();
        s_rvalid_i = 1; s_rdata_i = 32'hBAD;
        #2;
        n_checks++;
        if (ctl !== 7'b0 || m0_rdata_o !== 32'h0 || m1_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL stray: got %b/%h/%h expected 0/0/0", ctl, m0_rdata_o, m1_rdata_o);
        end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_reset_mid_m1();
        m1_req_i = 1; m1_addr_i = 32'hA00; s_gnt_i = 1;
        tick();
        s_gnt_i = 0; rst_ni = 0;
        #2;
        n_checks++;
        if (ctl !== 7'b0 || dat !== 128'b0) begin
            n_fail++; $display("FAIL reset_mid_m1: got %b/%h expected 0/0", ctl, dat);
        end
        tick();
        rst_ni = 1; m1_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h1234; m0_req_i = 1; m0_addr_i = 32'hB00;
        #2;
        n_checks++;
        if (ctl !== 7'b1000000 || m1_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_stray_resp: got %b/%h expected %b/0", ctl, m1_rdata_o, 7'b1000000);
        end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_fairness();
        int streak = 0;
        int exp_who, got_who;
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'hC00; m1_addr_i = 32'hD00;
        for (int t = 0; t < 10; t++) begin
            s_gnt_i = 1; s_rvalid_i = 0;
            #2;
            exp_who = (FAIR_ON && streak == int'(FAIR_LIMIT)) ? 0 : 1;
            got_who = m1_gnt_o ? 1 : (m0_gnt_o ? 0 : -1);
            n_checks++;
            if (got_who !== exp_who) begin
                n_fail++; $display("FAIL fair_grant[%0d]: got m%0d expected m%0d", t, got_who, exp_who);
            end
            streak = (exp_who == 1) ? streak + 1 : 0;
            tick();
            s_gnt_i = 0; s_rvalid_i = 1;
            tick();
        end
        idle_inputs(); tick();
    endtask

    task automatic test_random();
        int busy = -1, lock = -1, streak = 0, win;
        bit m0_pend = 0, m1_pend = 0;
        bit e_sreq, e_we, e_m0g, e_m1g, e_m0rv, e_m1rv, e_hold;
        logic [31:0] e_addr;
        for (int c = 0; c < 400; c++) begin
            if (!m0_pend && $urandom_range(2) == 0) begin m0_pend = 1; m0_addr_i = $urandom; end
            if (!m1_pend && $urandom_range(3) == 0) begin
                m1_pend = 1; m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_we_i = 1'($urandom);
            end
            m0_req_i = m0_pend; m1_req_i = m1_pend;
            s_gnt_i = 1'($urandom); s_rvalid_i = ($urandom_range(2) == 0);
            s_rdata_i = $urandom; m0_flush_i = ($urandom_range(7) == 0);
            win = -1;
            if (busy < 0) begin
                if (lock >= 0) win = lock;
                else if (FAIR_ON && m0_req_i && streak >= int'(FAIR_LIMIT)) win = 0;
                else if (m1_req_i) win = 1;
                else if (m0_req_i) win = 0;
            end
            e_sreq = (win >= 0);
            e_we   = (win == 1) && m1_we_i;
            e_m0g  = (win == 0) && s_gnt_i;
            e_m1g  = (win == 1) && s_gnt_i;
            e_m0rv = (busy == 0) && s_rvalid_i && !m0_flush_i;
            e_m1rv = (busy == 1) && s_rvalid_i;
            e_hold = m1_req_i || busy == 1 || lock == 1;
            e_addr = (win == 1) ? m1_addr_i : (win == 0) ? m0_addr_i : 32'h0;
            #2;
            n_checks++;
            if (ctl !== {e_sreq, e_we, e_m0g, e_m1g, e_m0rv, e_m1rv, e_hold}) begin
                n_fail++; $display("FAIL rand_ctl[%0d]: got %b expected %b", c, ctl,
                                   {e_sreq, e_we, e_m0g, e_m1g, e_m0rv, e_m1rv, e_hold});
            end
            n_checks++;
            if (s_addr_o !== e_addr) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", c, s_addr_o, e_addr); end
            n_checks++;
            if (m0_rdata_o !== (e_m0rv ? s_rdata_i : 32'h0)) begin
                n_fail++; $display("FAIL rand_m0_rdata[%0d]: got %h expected %h", c, m0_rdata_o, e_m0rv ? s_rdata_i : 32'h0);
            end
            n_checks++;
            if (m1_rdata_o !== (e_m1rv ? s_rdata_i : 32'h0)) begin
                n_fail++; $display("FAIL rand_m1_rdata[%0d]: got %h expected %h", c, m1_rdata_o, e_m1rv ? s_rdata_i : 32'h0);
            end
            if (busy < 0) begin
                if (win >= 0 && s_gnt_i) begin busy = win; lock = -1; end
                else if (win >= 0) lock = (win == 0 && m0_flush_i) ? -1 : win;
                else lock = -1;
            end else if (s_rvalid_i) busy = -1;
            else if (busy == 0 && m0_flush_i) busy = 2;
            if (!m0_req_i || e_m0g) streak = 0;
            else if (e_m1g && streak < 15) streak++;
            if (e_m0g) m0_pend = 0;
            if (e_m1g) m1_pend = 0;
            tick();
        end
        idle_inputs(); tick();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1;
        #1;
        test_reset();
        test_m0_fetch();
        test_m1_priority();
        test_lock();
        test_flush();
        test_flush_unlock();
        test_stray();
        test_reset_mid_m1();
        test_fairness();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
